vgapatgen: RTL

//  Parametrised successor to the fixed test-pattern source. Produces one RGB pixel per consumer read for
//  an HDMI/DVI serialiser driven by the i_rd/i_newline/i_newframe strobes. Resolution is set by parameters.

---
 rtl/vgapatgen_if.sv | 24 ++
 rtl/vgapatgen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/vgapatgen_if.sv
// rtl/vgapatgen_if.sv - pixel request/response bundle between consumer and pattern source
// The consumer drives strobes and the mode request; the source returns pixel and status.
interface vgapatgen_if #(
  parameter int BPC = 8
);
  logic [2:0]       i_mode;
  logic             i_rd;
  logic             i_newline;
  logic             i_newframe;
  logic [3*BPC-1:0] o_pixel;
  logic [2:0]       o_mode;
  logic [15:0]      o_frame_count;
  logic             o_overrun;

  modport master (
    output i_mode, i_rd, i_newline, i_newframe,
    input  o_pixel, o_mode, o_frame_count, o_overrun
  );

  modport slave (
    input  i_mode, i_rd, i_newline, i_newframe,
    output o_pixel, o_mode, o_frame_count, o_overrun
  );
endinterface

// File: rtl/vgapatgen.sv
// rtl/vgapatgen.sv - run-time selectable RGB test-pattern source with prefetched pixel output
// Mode is latched at frame start; the box steps once per frame and bounces off the active-area edges.
module vgapatgen #(
  parameter int          HW        = 640,
  parameter int          VW        = 480,
  parameter int          BPC       = 8,
  parameter int          CHK_LOG2  = 5,
  parameter int          BOX       = 32,
  parameter logic [23:0] SOLID_RGB = 24'h808080
) (
  input  logic        i_pixclk,
  input  logic        i_reset,
  vgapatgen_if.slave  bus
);
  localparam int XW   = $clog2(HW);
  localparam int YW   = $clog2(VW);
  localparam int BARW = HW / 8;
  localparam int BCW  = $clog2(BARW);

  localparam logic [XW-1:0]  X_LAST   = XW'(HW - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(VW - 1);
  localparam logic [XW-1:0]  BX_MAX   = XW'(HW - BOX);
  localparam logic [YW-1:0]  BY_MAX   = YW'(VW - BOX);
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BARW - 1);

  logic [XW-1:0]    x_q, x_d, bx_q, bx_d;
  logic [YW-1:0]    y_q, y_d, by_q, by_d;
  logic             dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]       bar_q, bar_d;
  logic [2:0]       mode_q, mode_d;
  logic [15:0]      frame_q, frame_d;
  logic             overrun_q, overrun_d;
  logic [3*BPC-1:0] pixel_q, pixel_d;
  logic             in_box;

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    bcnt_d    = bcnt_q;
    bar_d     = bar_q;
    mode_d    = mode_q;
    frame_d   = frame_q;
    overrun_d = overrun_q;
    if (bus.i_newframe) begin
      x_d       = '0;
      y_d       = '0;
      bcnt_d    = '0;
      bar_d     = '0;
      mode_d    = bus.i_mode;
      frame_d   = frame_q + 16'd1;
      overrun_d = 1'b0;
      // Hitting a limit flips direction and steps away in the same frame.
      if (!dx_neg_q) begin
        if (bx_q == BX_MAX) begin bx_d = bx_q - 1'b1; dx_neg_d = 1'b1; end
        else                       bx_d = bx_q + 1'b1;
      end else begin
        if (bx_q == '0) begin bx_d = bx_q + 1'b1; dx_neg_d = 1'b0; end
        else                   bx_d = bx_q - 1'b1;
      end
      if (!dy_neg_q) begin
        if (by_q == BY_MAX) begin by_d = by_q - 1'b1; dy_neg_d = 1'b1; end
        else                       by_d = by_q + 1'b1;
      end else begin
        if (by_q == '0) begin by_d = by_q + 1'b1; dy_neg_d = 1'b0; end
        else                   by_d = by_q - 1'b1;
      end
    end else if (bus.i_newline) begin
      x_d    = '0;
      bcnt_d = '0;
      bar_d  = '0;
      if (y_q == Y_LAST) overrun_d = 1'b1;
      else               y_d = y_q + 1'b1;
    end else if (bus.i_rd) begin
      if (x_q == X_LAST) begin
        overrun_d = 1'b1;
      end else begin
        x_d = x_q + 1'b1;
        if (bcnt_q == BAR_LAST) begin
          bcnt_d = '0;
          bar_d  = bar_q + 1'b1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end
  end

  assign in_box = ({1'b0, x_q} >= {1'b0, bx_q}) &&
                  ({1'b0, x_q} <  ({1'b0, bx_q} + (XW+1)'(BOX))) &&
                  ({1'b0, y_q} >= {1'b0, by_q}) &&
                  ({1'b0, y_q} <  ({1'b0, by_q} + (YW+1)'(BOX)));

  // Bar colour bits fall straight out of the bar index: R=~b1, G=~b2, B=~b0.
  always_comb begin
    pixel_d = '0;
    case (mode_q)
      3'd0: pixel_d = {SOLID_RGB[23 -: BPC], SOLID_RGB[15 -: BPC], SOLID_RGB[7 -: BPC]};
      3'd1: pixel_d = {{BPC{~bar_q[1]}}, {BPC{~bar_q[2]}}, {BPC{~bar_q[0]}}};
      3'd2: pixel_d = (x_q[CHK_LOG2] ^ y_q[CHK_LOG2]) ? '1 : '0;
      3'd3: pixel_d = {3{x_q[BPC-1:0]}};
      3'd4: pixel_d = in_box ? '1 : {{(2*BPC){1'b0}}, {BPC{1'b1}}};
      default: pixel_d = '0;
    endcase
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      x_q       <= '0;
      y_q       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
      bcnt_q    <= '0;
      bar_q     <= '0;
      mode_q    <= '0;
      frame_q   <= '0;
      overrun_q <= 1'b0;
      pixel_q   <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_neg_q  <= dx_neg_d;
      dy_neg_q  <= dy_neg_d;
      bcnt_q    <= bcnt_d;
      bar_q     <= bar_d;
      mode_q    <= mode_d;
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
      pixel_q   <= pixel_d;
    end
  end

  assign bus.o_pixel       = pixel_q;
  assign bus.o_mode        = mode_q;
  assign bus.o_frame_count = frame_q;
  assign bus.o_overrun     = overrun_q;
endmodule
